// File: rtl/qspi_cmd.sv
// qspi_cmd: decodes qspi command/data bytes into register-bus writes, reads and echo replies.
// Build option: define QSPI_CMD_ECHO_EN to compile in the ECHO command and its byte buffer.
module qspi_cmd #(
  parameter int unsigned ECHO_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd,
  input  logic       cmd_ready,
  input  logic [7:0] data_read,
  input  logic       data_ready,
  output logic [7:0] data_write,
  output logic       we,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  input  logic [7:0] bus_rdata
);

  typedef enum logic [2:0] {IDLE, ADDR, WRITE, READ, ECHO_RX, ECHO_TX, IGNORE} state_e;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  if ((ECHO_LEN < 1) || (ECHO_LEN > 16)) begin : g_bad_echo_len
    $error("qspi_cmd: ECHO_LEN must be in 1..16");
  end

  state_e     state_q, state_d;
  logic       is_read_q, is_read_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       bus_we_q, bus_we_d;
  logic [7:0] dw_q, dw_d;
  logic       we_q, we_d;
  logic       rd_load_q, rd_load_d;

`ifdef QSPI_CMD_ECHO_EN
  localparam logic [7:0]  CMD_ECHO = 8'h9F;
  localparam int unsigned CW       = (ECHO_LEN > 1) ? $clog2(ECHO_LEN) : 1;
  localparam logic [CW-1:0] LAST   = CW'(ECHO_LEN - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    echo_buf [ECHO_LEN];
  logic          buf_wr;

  always_ff @(posedge clk) begin
    if (buf_wr) echo_buf[cnt_q] <= data_read;
  end
`endif

  always_comb begin
    state_d   = state_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bus_we_d  = 1'b0;
    dw_d      = dw_q;
    we_d      = we_q;
    rd_load_d = 1'b0;
`ifdef QSPI_CMD_ECHO_EN
    cnt_d     = cnt_q;
    buf_wr    = 1'b0;
`endif
    // Address steps the cycle after each strobe, so back-to-back bytes land on consecutive addresses
    if (bus_we_q) addr_d = addr_q + 8'd1;

    if (cmd_ready) begin
      we_d = 1'b0;
`ifdef QSPI_CMD_ECHO_EN
      cnt_d = '0;
`endif
      case (cmd)
        CMD_WRITE: begin state_d = ADDR; is_read_d = 1'b0; end
        CMD_READ:  begin state_d = ADDR; is_read_d = 1'b1; end
`ifdef QSPI_CMD_ECHO_EN
        CMD_ECHO:  state_d = ECHO_RX;
`endif
        default:   state_d = IGNORE;
      endcase
    end else begin
      case (state_q)
        ADDR: if (data_ready) begin
          addr_d    = data_read;
          state_d   = is_read_q ? READ : WRITE;
          rd_load_d = is_read_q;
        end
        WRITE: if (data_ready) begin
          wdata_d  = data_read;
          bus_we_d = 1'b1;
        end
        READ: begin
          if (rd_load_q) begin
            dw_d = bus_rdata;
            we_d = 1'b1;
          end
          if (data_ready) begin
            addr_d    = addr_q + 8'd1;
            rd_load_d = 1'b1;
          end
        end
`ifdef QSPI_CMD_ECHO_EN
        ECHO_RX: if (data_ready) begin
          buf_wr = 1'b1;
          if (cnt_q == LAST) begin
            state_d = ECHO_TX;
            cnt_d   = '0;
            we_d    = 1'b1;
            // With a one-byte echo, buffer[0] is still being written this cycle
            dw_d    = (cnt_q == '0) ? data_read : echo_buf[0];
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ECHO_TX: if (data_ready) begin
          if (cnt_q == LAST) begin
            state_d = IDLE;
            we_d    = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
            dw_d  = echo_buf[cnt_q + CW'(1)];
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bus_we_q  <= 1'b0;
      dw_q      <= '0;
      we_q      <= 1'b0;
      rd_load_q <= 1'b0;
`ifdef QSPI_CMD_ECHO_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bus_we_q  <= bus_we_d;
      dw_q      <= dw_d;
      we_q      <= we_d;
      rd_load_q <= rd_load_d;
`ifdef QSPI_CMD_ECHO_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign data_write = dw_q;
  assign we         = we_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_we     = bus_we_q;

endmodule

// File: tb/tb_qspi_cmd.sv
// Self-checking bench for qspi_cmd: directed table, timing corner sequences and random transactions.
`timescale 1ns/1ps
module tb_qspi_cmd;

  localparam int ECHO_LEN = 8;
  localparam int K_IGN = 0, K_WRITE = 1, K_READ = 2, K_ECHO = 3;
  localparam int NV = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cmd, data_read, data_write, bus_addr, bus_wdata, bus_rdata;
  logic       cmd_ready, data_ready, we, bus_we;

  qspi_cmd #(.ECHO_LEN(ECHO_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_ready(cmd_ready),
    .data_read(data_read), .data_ready(data_ready), .data_write(data_write), .we(we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Register-bus slave: memory preloaded with ~addr
  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] <= ~8'(i);
  always @(posedge clk) if (bus_we) mem[bus_addr] <= bus_wdata;
  assign bus_rdata = mem[bus_addr];

  logic [15:0] obs_wr_q[$];
  logic [15:0] exp_wr_q[$];
  logic [7:0]  obs_tx_q[$];
  always @(negedge clk) if (rst_n === 1'b1 && bus_we === 1'b1) obs_wr_q.push_back({bus_addr, bus_wdata});

  logic [7:0] model_mem [256];
  logic [7:0] t_b [16];
  logic       we_end;
  int vectors = 0, miscompares = 0;

  typedef struct {
    logic [7:0]  cmd;
    int          nb;
    logic [7:0]  b [16];
    int          nwr;
    logic [15:0] wr [4];
    int          ntx;
    logic [7:0]  tx [16];
    logic        we_end;
  } vec_t;
  vec_t vt [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int kind_of(input logic [7:0] c);
    if (c == 8'h02) return K_WRITE;
    if (c == 8'h0B) return K_READ;
`ifdef QSPI_CMD_ECHO_EN
    if (c == 8'h9F) return K_ECHO;
`endif
    return K_IGN;
  endfunction

  // Expected we level just before byte i of a transaction (i == nb: after the last byte)
  function automatic logic exp_we(input int k, input int i);
    case (k)
      K_READ:  return i >= 1;
      K_ECHO:  return (i >= ECHO_LEN) && (i < 2 * ECHO_LEN);
      default: return 1'b0;
    endcase
  endfunction

  task automatic send_cmd(input logic [7:0] c);
    @(negedge clk); cmd = c; cmd_ready = 1'b1;
    @(negedge clk); cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_byte(input logic [7:0] d);
    data_read = d; data_ready = 1'b1;
    @(negedge clk); data_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_txn(input logic [7:0] c, input int nb);
    int k;
    logic [7:0] a, ex;
    logic ew;
    k = kind_of(c);
    obs_wr_q.delete(); exp_wr_q.delete(); obs_tx_q.delete();
    send_cmd(c);
    for (int i = 0; i <= nb; i++) begin
      ew = exp_we(k, i);
      check($sformatf("we[%0d] cmd %h", i, c), 32'(we), 32'(ew));
      if (ew) begin
        if (k == K_READ) ex = model_mem[t_b[0] + 8'(i - 1)];
        else             ex = t_b[i - ECHO_LEN];
        check($sformatf("data_write[%0d] cmd %h", i, c), 32'(data_write), 32'(ex));
      end
      if (i < nb) begin
        if (we === 1'b1) obs_tx_q.push_back(data_write);
        if (k == K_WRITE && i >= 1) begin
          a = t_b[0] + 8'(i - 1);
          exp_wr_q.push_back({a, t_b[i]});
          model_mem[a] = t_b[i];
        end
        pulse_byte(t_b[i]);
      end
    end
    we_end = we;
    check($sformatf("bus_we count cmd %h", c), obs_wr_q.size(), exp_wr_q.size());
    for (int j = 0; j < exp_wr_q.size() && j < obs_wr_q.size(); j++)
      check($sformatf("bus write %0d cmd %h", j, c), obs_wr_q[j], exp_wr_q[j]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " we"}, 32'(we), 0);
    check({tag, " data_write"}, 32'(data_write), 0);
    check({tag, " bus_addr"}, 32'(bus_addr), 0);
    check({tag, " bus_wdata"}, 32'(bus_wdata), 0);
    check({tag, " bus_we"}, 32'(bus_we), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] c;
    int nb;
    for (int i = 0; i < 256; i++) model_mem[i] = ~8'(i);
    rst_n = 1'b0; cmd = '0; cmd_ready = 1'b0; data_read = '0; data_ready = 1'b0;

    // Directed table
    for (int v = 0; v < NV; v++) begin
      vt[v].nb = 0; vt[v].nwr = 0; vt[v].ntx = 0; vt[v].we_end = 1'b0;
      for (int j = 0; j < 16; j++) begin vt[v].b[j] = 8'($urandom); vt[v].tx[j] = '0; end
      for (int j = 0; j < 4; j++) vt[v].wr[j] = '0;
    end
    vt[0].cmd = 8'h02; vt[0].nb = 3; vt[0].b[0] = 8'h10; vt[0].b[1] = 8'hA5; vt[0].b[2] = 8'h5A;
    vt[0].nwr = 2; vt[0].wr[0] = 16'h10A5; vt[0].wr[1] = 16'h115A;
    vt[1].cmd = 8'h0B; vt[1].nb = 4; vt[1].b[0] = 8'hFE;
    vt[1].ntx = 3; vt[1].tx[0] = 8'h01; vt[1].tx[1] = 8'h00; vt[1].tx[2] = 8'hFF; vt[1].we_end = 1'b1;
    vt[2].cmd = 8'h9F; vt[2].nb = 16;
`ifdef QSPI_CMD_ECHO_EN
    vt[2].ntx = 8;
    for (int j = 0; j < 8; j++) vt[2].tx[j] = vt[2].b[j];
`endif
    vt[3].cmd = 8'h9F; vt[3].nb = 3;
    vt[4].cmd = 8'h02; vt[4].nb = 2; vt[4].b[0] = 8'h20; vt[4].b[1] = 8'h33;
    vt[4].nwr = 1; vt[4].wr[0] = 16'h2033;
    vt[5].cmd = 8'h77; vt[5].nb = 4;
    vt[6].cmd = 8'h0B; vt[6].nb = 1; vt[6].b[0] = 8'h30; vt[6].we_end = 1'b1;
    vt[7].cmd = 8'h02; vt[7].nb = 3; vt[7].b[0] = 8'hFF; vt[7].b[1] = 8'hC1; vt[7].b[2] = 8'hC2;
    vt[7].nwr = 2; vt[7].wr[0] = 16'hFFC1; vt[7].wr[1] = 16'h00C2;

    repeat (3) @(negedge clk);
    check_outputs_zero("in reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("after reset");

    for (int v = 0; v < NV; v++) begin
      for (int j = 0; j < 16; j++) t_b[j] = vt[v].b[j];
      run_txn(vt[v].cmd, vt[v].nb);
      check($sformatf("tbl%0d nwr", v), obs_wr_q.size(), vt[v].nwr);
      for (int j = 0; j < vt[v].nwr && j < obs_wr_q.size(); j++)
        check($sformatf("tbl%0d wr%0d", v, j), obs_wr_q[j], vt[v].wr[j]);
      check($sformatf("tbl%0d ntx", v), obs_tx_q.size(), vt[v].ntx);
      for (int j = 0; j < vt[v].ntx && j < obs_tx_q.size(); j++)
        check($sformatf("tbl%0d tx%0d", v, j), 32'(obs_tx_q[j]), 32'(vt[v].tx[j]));
      check($sformatf("tbl%0d we_end", v), 32'(we_end), 32'(vt[v].we_end));
    end

    // READ entry latency: bus_addr one cycle, we/data_write two cycles after the address byte
    send_cmd(8'h0B);
    data_read = 8'h40; data_ready = 1'b1;
    @(negedge clk); data_ready = 1'b0;
    check("rd entry bus_addr", 32'(bus_addr), 32'h40);
    check("rd entry we early", 32'(we), 0);
    @(negedge clk);
    check("rd entry we", 32'(we), 1);
    check("rd entry data_write", 32'(data_write), 32'(model_mem[8'h40]));
    repeat (2) @(negedge clk);

    // Command and data in the same cycle: data byte dropped
    send_cmd(8'h02); pulse_byte(8'h50);
    obs_wr_q.delete();
    cmd = 8'h02; cmd_ready = 1'b1; data_read = 8'hEE; data_ready = 1'b1;
    @(negedge clk); cmd_ready = 1'b0; data_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("same-cycle no strobe", obs_wr_q.size(), 0);
    pulse_byte(8'h60); pulse_byte(8'h77); model_mem[8'h60] = 8'h77;
    check("same-cycle writes", obs_wr_q.size(), 1);
    if (obs_wr_q.size() > 0) check("same-cycle wr", obs_wr_q[0], 16'h6077);

    // Byte arriving while a strobe is pending
    send_cmd(8'h02); pulse_byte(8'h70);
    obs_wr_q.delete();
    data_read = 8'hC3; data_ready = 1'b1;
    @(negedge clk); data_read = 8'h3C;
    @(negedge clk); data_ready = 1'b0;
    repeat (3) @(negedge clk);
    model_mem[8'h70] = 8'hC3; model_mem[8'h71] = 8'h3C;
    check("pending writes", obs_wr_q.size(), 2);
    if (obs_wr_q.size() > 1) begin
      check("pending wr0", obs_wr_q[0], 16'h70C3);
      check("pending wr1", obs_wr_q[1], 16'h713C);
    end
    check("pending addr after", 32'(bus_addr), 32'h72);

    // Reset mid-READ
    t_b[0] = 8'h80;
    run_txn(8'h0B, 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid-read reset");
    @(negedge clk); rst_n = 1'b1;
    t_b[0] = 8'hA0; t_b[1] = 8'h12;
    run_txn(8'h02, 2);
    check("post-reset write", obs_wr_q.size(), 1);
    if (obs_wr_q.size() > 0) check("post-reset wr", obs_wr_q[0], 16'hA012);

    // Random transactions against the reference model
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: c = 8'h02;
        1: c = 8'h0B;
        2: c = 8'h9F;
        default: do c = 8'($urandom); while (c == 8'h02 || c == 8'h0B || c == 8'h9F);
      endcase
      nb = $urandom_range(0, 16);
      for (int j = 0; j < 16; j++) t_b[j] = 8'($urandom);
      run_txn(c, nb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
